// File: rtl/pulse_analyzer_pkg.sv
// Shared sizes, FSM state type and pulse record layout for pulse_analyzer.
// The optional area accumulator is selected with PULSE_ANALYZER_AREA_EN.
package pulse_analyzer_pkg;

    localparam int SIZE_FILTER_DATA = 16;
    localparam int SIZE_TIMESTAMP   = 32;
    localparam int SIZE_WIDTH       = 8;
    localparam int SIZE_AREA        = SIZE_FILTER_DATA + SIZE_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HOLD
    } pulse_state_t;

    // "time" is a reserved word, so the peak timestamp field is peak_time.
    typedef struct packed {
        logic signed [SIZE_FILTER_DATA-1:0] amplitude;
        logic        [SIZE_TIMESTAMP-1:0]   peak_time;
        logic        [SIZE_WIDTH-1:0]       width;
        logic signed [SIZE_AREA-1:0]        area;
        logic                               pile_up;
    } pulse_record_t;

    // Signed add of one sample onto the area accumulator, clamped to the
    // representable range instead of wrapping.
    function automatic logic signed [SIZE_AREA-1:0] sat_add_area(
        input logic signed [SIZE_AREA-1:0]        acc,
        input logic signed [SIZE_FILTER_DATA-1:0] s
    );
        logic signed [SIZE_AREA:0] sum;
        sum = {acc[SIZE_AREA-1], acc}
            + {{(SIZE_AREA + 1 - SIZE_FILTER_DATA){s[SIZE_FILTER_DATA-1]}}, s};
        if (sum[SIZE_AREA] != sum[SIZE_AREA-1]) begin
            if (sum[SIZE_AREA]) begin
                return {1'b1, {(SIZE_AREA - 1){1'b0}}};
            end
            return {1'b0, {(SIZE_AREA - 1){1'b1}}};
        end
        return sum[SIZE_AREA-1:0];
    endfunction

endpackage

// File: rtl/pulse_analyzer_record_buffer.sv
// Single-entry valid/ready holding register for finished pulse records.
// A record arriving while the held one is still waiting is dropped and
// counted in a saturating lost counter.
module pulse_record_buffer
    import pulse_analyzer_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          emit,
    input  pulse_record_t record_in,
    input  logic          ready,
    output logic          valid,
    output pulse_record_t record_out,
    output logic [7:0]    lost_count
);

    // Load on emit when the slot is free or being drained, otherwise drop and count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid      <= 1'b0;
            record_out <= '0;
            lost_count <= 8'd0;
        end else if (emit) begin
            if (!valid || ready) begin
                record_out <= record_in;
                valid      <= 1'b1;
            end else if (lost_count != 8'hFF) begin
                lost_count <= lost_count + 8'd1;
            end
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pulse_analyzer.sv
// Threshold-triggered pulse measurement on a filter output stream.
// Reports peak, peak timestamp, width, pile-up and (when built with
// PULSE_ANALYZER_AREA_EN) the saturating area of each pulse.
module pulse_analyzer
    import pulse_analyzer_pkg::*;
#(
    parameter int HOLDOFF   = 4,
    parameter int MAX_WIDTH = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic signed [SIZE_FILTER_DATA-1:0] input_data,
    input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
    input  logic                               pulse_ready,
    output logic                               pulse_valid,
    output logic signed [SIZE_FILTER_DATA-1:0] pulse_amplitude,
    output logic        [SIZE_TIMESTAMP-1:0]   pulse_time,
    output logic        [SIZE_WIDTH-1:0]       pulse_width,
    output logic signed [SIZE_AREA-1:0]        pulse_area,
    output logic                               pulse_pile_up,
    output logic        [7:0]                  lost_count
);

    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (HOLDOFF > 0) ? HOLD_W'(HOLDOFF - 1) : '0;
    localparam logic [SIZE_WIDTH-1:0] WIDTH_SAT = '1;
    localparam logic PILE_AT_TRIGGER = (MAX_WIDTH <= 1);

    pulse_state_t state;
    pulse_state_t next_state;

    logic signed [SIZE_FILTER_DATA-1:0] sample;
    logic        [SIZE_TIMESTAMP-1:0]   sample_ts;
    logic        [SIZE_TIMESTAMP-1:0]   ts_counter;

    logic signed [SIZE_FILTER_DATA-1:0] thr_l;
    logic signed [SIZE_FILTER_DATA-1:0] peak;
    logic        [SIZE_TIMESTAMP-1:0]   peak_time;
    logic        [SIZE_WIDTH-1:0]       width;
    logic                               pile_up;
    logic signed [SIZE_AREA-1:0]        area_value;
    logic        [HOLD_W-1:0]           hold_cnt;

    logic trigger;
    logic extend;
    logic emit;

    pulse_record_t pending_record;
    pulse_record_t held_record;

    // Sample register, its capture timestamp and the free-running counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample     <= '0;
            sample_ts  <= '0;
            ts_counter <= '0;
        end else begin
            sample     <= input_data;
            sample_ts  <= ts_counter;
            ts_counter <= ts_counter + SIZE_TIMESTAMP'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the trigger/extend/emit strobes for the datapath.
    always_comb begin
        next_state = state;
        trigger    = 1'b0;
        extend     = 1'b0;
        emit       = 1'b0;
        case (state)
            IDLE: begin
                if (sample >= threshold) begin
                    trigger    = 1'b1;
                    next_state = ACTIVE;
                end
            end
            ACTIVE: begin
                if (sample >= thr_l) begin
                    extend = 1'b1;
                end else begin
                    emit       = 1'b1;
                    next_state = (HOLDOFF == 0) ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Holdoff counter runs only while in HOLD and restarts at zero otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
        end else if (state == HOLD) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end else begin
            hold_cnt <= '0;
        end
    end

    // Per-pulse measurements: latched threshold, peak (first of equals), width, pile-up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            thr_l     <= '0;
            peak      <= '0;
            peak_time <= '0;
            width     <= '0;
            pile_up   <= 1'b0;
        end else if (trigger) begin
            thr_l     <= threshold;
            peak      <= sample;
            peak_time <= sample_ts;
            width     <= SIZE_WIDTH'(1);
            pile_up   <= PILE_AT_TRIGGER;
        end else if (extend) begin
            if (width != WIDTH_SAT) begin
                width <= width + SIZE_WIDTH'(1);
            end
            if (int'(width) + 1 >= MAX_WIDTH) begin
                pile_up <= 1'b1;
            end
            if (sample > peak) begin
                peak      <= sample;
                peak_time <= sample_ts;
            end
        end
    end

`ifdef PULSE_ANALYZER_AREA_EN
    logic signed [SIZE_AREA-1:0] area;

    // Saturating running sum of the samples that belong to the pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            area <= '0;
        end else if (trigger) begin
            area <= sat_add_area('0, sample);
        end else if (extend) begin
            area <= sat_add_area(area, sample);
        end
    end

    assign area_value = area;
`else
    assign area_value = '0;
`endif

    // Assemble the record presented to the output buffer on emit.
    always_comb begin
        pending_record           = '0;
        pending_record.amplitude = peak;
        pending_record.peak_time = peak_time;
        pending_record.width     = width;
        pending_record.area      = area_value;
        pending_record.pile_up   = pile_up;
    end

    pulse_record_buffer u_buffer (
        .clk        (clk),
        .reset      (reset),
        .emit       (emit),
        .record_in  (pending_record),
        .ready      (pulse_ready),
        .valid      (pulse_valid),
        .record_out (held_record),
        .lost_count (lost_count)
    );

    assign pulse_amplitude = held_record.amplitude;
    assign pulse_time      = held_record.peak_time;
    assign pulse_width     = held_record.width;
    assign pulse_area      = held_record.area;
    assign pulse_pile_up   = held_record.pile_up;

endmodule

// File: tb/tb_pulse_analyzer.sv
// Scoreboard testbench for pulse_analyzer: a sample-list reference model
// pushes expected records, a negedge monitor pops and compares them.
module tb_pulse_analyzer;
    import pulse_analyzer_pkg::*;

    localparam int HOLDOFF   = 4;
    localparam int MAX_WIDTH = 64;
    localparam longint AREA_MAX = (longint'(1) << (SIZE_AREA - 1)) - 1;
    localparam longint AREA_MIN = -(longint'(1) << (SIZE_AREA - 1));

    logic                               clk;
    logic                               reset;
    logic signed [SIZE_FILTER_DATA-1:0] input_data;
    logic signed [SIZE_FILTER_DATA-1:0] threshold;
    logic                               pulse_ready;
    logic                               pulse_valid;
    logic signed [SIZE_FILTER_DATA-1:0] pulse_amplitude;
    logic        [SIZE_TIMESTAMP-1:0]   pulse_time;
    logic        [SIZE_WIDTH-1:0]       pulse_width;
    logic signed [SIZE_AREA-1:0]        pulse_area;
    logic                               pulse_pile_up;
    logic        [7:0]                  lost_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint amp;
        longint tm;
        longint width;
        longint area;
        longint pile;
        longint cyc;
    } exp_t;

    exp_t expq[$];

    pulse_analyzer #(
        .HOLDOFF   (HOLDOFF),
        .MAX_WIDTH (MAX_WIDTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .input_data      (input_data),
        .threshold       (threshold),
        .pulse_ready     (pulse_ready),
        .pulse_valid     (pulse_valid),
        .pulse_amplitude (pulse_amplitude),
        .pulse_time      (pulse_time),
        .pulse_width     (pulse_width),
        .pulse_area      (pulse_area),
        .pulse_pile_up   (pulse_pile_up),
        .lost_count      (lost_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation did not complete in time");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint edge_num;
    longint ts_count;
    int     prev_s;
    longint prev_ts;
    bit     in_pulse;
    int     thr_latched;
    int     hold_left;
    bit     m_full;
    int     m_lost;
    int     pq[$];
    longint tq[$];

    function automatic exp_t buildRecord(longint cyc);
        exp_t   e;
        int     best;
        longint acc;
        best = 0;
        acc  = 0;
        for (int i = 0; i < pq.size(); i++) begin
            if (pq[i] > pq[best]) best = i;
            acc += pq[i];
            if (acc > AREA_MAX) acc = AREA_MAX;
            if (acc < AREA_MIN) acc = AREA_MIN;
        end
        e.amp   = pq[best];
        e.tm    = tq[best];
        e.width = (pq.size() > 255) ? 255 : pq.size();
        e.pile  = (e.width >= MAX_WIDTH) ? 1 : 0;
`ifdef PULSE_ANALYZER_AREA_EN
        e.area  = acc;
`else
        e.area  = 0;
`endif
        e.cyc   = cyc;
        return e;
    endfunction

    // Model: each edge judges the sample captured on the previous edge.
    always @(posedge clk) begin
        bit   emit;
        exp_t rec;
        int   thr_now;
        if (!reset) begin
            edge_num = 0;
            ts_count = 0;
            prev_s   = 0;
            prev_ts  = 0;
            in_pulse = 0;
            hold_left = 0;
            m_full   = 0;
            m_lost   = 0;
            pq.delete();
            tq.delete();
            expq.delete();
        end else begin
            edge_num++;
            emit    = 0;
            thr_now = threshold;
            if (hold_left > 0) begin
                hold_left--;
            end else if (!in_pulse) begin
                if (prev_s >= thr_now) begin
                    in_pulse    = 1;
                    thr_latched = thr_now;
                    pq.delete();
                    tq.delete();
                    pq.push_back(prev_s);
                    tq.push_back(prev_ts);
                end
            end else if (prev_s >= thr_latched) begin
                pq.push_back(prev_s);
                tq.push_back(prev_ts);
            end else begin
                rec       = buildRecord(edge_num);
                emit      = 1;
                in_pulse  = 0;
                hold_left = HOLDOFF;
            end
            if (emit) begin
                if (!m_full || pulse_ready) begin
                    expq.push_back(rec);
                    m_full = 1;
                end else if (m_lost < 255) begin
                    m_lost++;
                end
            end else if (m_full && pulse_ready) begin
                m_full = 0;
            end
            prev_s  = input_data;
            prev_ts = ts_count;
            ts_count++;
        end
    end

    // ---------------- monitor ----------------
    bit     prev_valid;
    bit     prev_ready;
    longint h_amp, h_tm, h_width, h_area, h_pile;

    // Compare each newly presented record and check held records stay put.
    always @(negedge clk) begin
        bit   new_rec;
        exp_t e;
        if (!reset) begin
            prev_valid = 0;
            prev_ready = 0;
        end else begin
            new_rec = pulse_valid && !(prev_valid && !prev_ready);
            if (pulse_valid && prev_valid && !prev_ready) begin
                checkOutput("record_stable",
                    ((pulse_amplitude == h_amp) && (pulse_time == h_tm) &&
                     (pulse_width == h_width) && (pulse_area == h_area) &&
                     (pulse_pile_up == h_pile)) ? 1 : 0, 1);
            end
            if (prev_valid && !prev_ready) begin
                checkOutput("valid_held", pulse_valid, 1);
            end
            if (new_rec) begin
                if (expq.size() == 0) begin
                    checkOutput("unexpected_record", 1, 0);
                end else begin
                    e = expq[0];
                    checkOutput("valid_cycle", edge_num, e.cyc);
                    checkOutput("amplitude", longint'(pulse_amplitude), e.amp);
                    checkOutput("peak_time", longint'(pulse_time), e.tm);
                    checkOutput("width", longint'(pulse_width), e.width);
                    checkOutput("area", longint'(pulse_area), e.area);
                    checkOutput("pile_up", longint'(pulse_pile_up), e.pile);
                end
            end
            if (pulse_valid && pulse_ready && expq.size() > 0) begin
                void'(expq.pop_front());
            end
            prev_valid = pulse_valid;
            prev_ready = pulse_ready;
            h_amp   = pulse_amplitude;
            h_tm    = pulse_time;
            h_width = pulse_width;
            h_area  = pulse_area;
            h_pile  = pulse_pile_up;
        end
    end

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input int s, input bit rdy);
        @(posedge clk);
        #2;
        input_data  = SIZE_FILTER_DATA'(s);
        pulse_ready = rdy;
    endtask

    task automatic applyRepeat(input int s, input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(s, rdy);
    endtask

    task automatic applySeq(input int seq[$], input bit rdy);
        foreach (seq[i]) applyStimulus(seq[i], rdy);
    endtask

    task automatic waitDrain(input string name);
        bit drained;
        drained = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (expq.size() == 0 && !pulse_valid) begin
                drained = 1;
                break;
            end
        end
        checkOutput(name, drained, 1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, pulse_valid, 0);
        checkOutput({tag, "_amplitude"}, longint'(pulse_amplitude), 0);
        checkOutput({tag, "_time"}, longint'(pulse_time), 0);
        checkOutput({tag, "_width"}, longint'(pulse_width), 0);
        checkOutput({tag, "_area"}, longint'(pulse_area), 0);
        checkOutput({tag, "_pile_up"}, pulse_pile_up, 0);
        checkOutput({tag, "_lost"}, lost_count, 0);
    endtask

    initial begin
        reset       = 1'b0;
        input_data  = '0;
        threshold   = 16'sd100;
        pulse_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk);
        #2;
        reset = 1'b1;

        $display("[TB] basic pulse");
        applyRepeat(0, 3, 1);
        applySeq('{0, 50, 150, 300, 200, 120, 80, 0}, 1);
        applyRepeat(0, 8, 1);
        waitDrain("drain_basic");

        $display("[TB] equal peaks");
        applySeq('{100, 250, 250, 90}, 1);
        applyRepeat(0, 8, 1);
        waitDrain("drain_equal");

        $display("[TB] pile-up");
        applyRepeat(500, 70, 1);
        applyRepeat(0, 8, 1);
        waitDrain("drain_pileup");

        $display("[TB] back-pressure");
        applySeq('{200, 200, 50}, 0);
        applyRepeat(0, 8, 0);
        applySeq('{300, 50}, 0);
        applyRepeat(0, 8, 0);
        checkOutput("lost_after_drop", lost_count, m_lost);
        checkOutput("lost_is_one", lost_count, 1);
        applyRepeat(0, 4, 1);
        waitDrain("drain_backpressure");

        $display("[TB] threshold change mid-pulse");
        applyRepeat(400, 2, 1);
        threshold = 16'sd1000;
        applyRepeat(400, 4, 1);
        applySeq('{50}, 1);
        applyRepeat(0, 8, 1);
        threshold = 16'sd100;
        waitDrain("drain_thrchange");

        $display("[TB] reset mid-pulse");
        applySeq('{200, 50}, 0);
        applyRepeat(0, 6, 0);
        applyRepeat(300, 3, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkAllZero("midreset");
        @(posedge clk);
        #2;
        reset       = 1'b1;
        pulse_ready = 1'b1;
        applySeq('{0, 150, 250, 50}, 1);
        applyRepeat(0, 8, 1);
        waitDrain("drain_after_reset");

        $display("[TB] width and area saturation");
        applyRepeat(32767, 300, 1);
        applyRepeat(0, 8, 1);
        waitDrain("drain_saturation");

        $display("[TB] random traffic");
        for (int b = 0; b < 10; b++) begin
            threshold = SIZE_FILTER_DATA'(int'($urandom_range(50, 300)));
            for (int i = 0; i < 40; i++) begin
                applyStimulus(int'($urandom_range(0, 800)) - 200, ($urandom_range(0, 3) != 0));
            end
        end
        applyRepeat(0, 10, 1);
        waitDrain("drain_random");
        checkOutput("lost_final", lost_count, m_lost);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_analyzer.md
# pulse_analyzer

Pulse analyzer that reads one filter output stream (signed, SIZE_FILTER_DATA bits) and turns each threshold crossing into a measured pulse record: peak amplitude, peak timestamp, width, optional area and a pile-up flag. It sits downstream of a vN_filter instance, on the filter output, and delivers records to the readout side over a valid/ready handshake.

## Interface
- HOLDOFF, 4: cycles after a pulse ends during which new triggers are ignored (0 allowed).
- MAX_WIDTH, 64: width (samples) at which the pulse is flagged as pile-up.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- input_data  in  SIZE_FILTER_DATA  signed filter sample, one per clk.
- threshold  in  SIZE_FILTER_DATA  signed trigger level.
- pulse_ready  in  1  consumer accepts the record this cycle.
- pulse_valid  out  1  record on outputs is valid.
- pulse_amplitude  out  SIZE_FILTER_DATA  signed peak sample value.
- pulse_time  out  SIZE_TIMESTAMP  timestamp of the peak sample.
- pulse_width  out  SIZE_WIDTH  number of samples >= threshold.
- pulse_area  out  SIZE_AREA  signed sum of samples >= threshold.
- pulse_pile_up  out  1  width reached MAX_WIDTH.
- lost_count  out  8  records dropped due to back-pressure, saturating.

## Operation
- input_data registered once (sample register); all decisions use the registered sample s.
- Free-running timestamp counter, SIZE_TIMESTAMP bits, increments every clk, wraps to 0 silently.
- FSM states: IDLE, ACTIVE, HOLD.
- IDLE: s >= threshold -> ACTIVE; threshold latched into thr_l, peak=s, peak_time=timestamp of s, width=1, area=s.
- ACTIVE: s >= thr_l -> width+1 (saturating at 2^SIZE_WIDTH-1), area+=s (saturating signed); s > peak (strict) -> update peak and peak_time; ties keep first peak. width reaching MAX_WIDTH sets pile_up sticky for this pulse; pulse continues.
- ACTIVE: s < thr_l -> record emitted, go HOLD (or IDLE if HOLDOFF=0).
- HOLD: counts HOLDOFF cycles, ignores input, then IDLE. A sample above threshold on the IDLE-return cycle triggers normally.
- threshold changes during ACTIVE have no effect until the next trigger.
- Output buffer (one record): emit while empty or (pulse_valid && pulse_ready) -> load record, pulse_valid=1. Emit while pulse_valid && !pulse_ready -> new record dropped, lost_count+1 (saturates at 255), held record unchanged.
- pulse_valid && pulse_ready without emit -> pulse_valid=0 next cycle.
- Record outputs stable while pulse_valid && !pulse_ready.

## Timing
- Reset (async, low): all outputs 0, FSM IDLE, timestamp 0, lost_count 0, sample register 0; reset mid-pulse discards the pulse and any held record.
- Sample on input_data at edge k is s from k to k+1; FSM transition at edge k+1.
- Latency: first below-threshold sample captured at edge k -> pulse_valid high from edge k+1.
- Trigger latency: above-threshold sample captured at edge k -> ACTIVE from edge k+1; its timestamp is the counter value at edge k.
- Throughput: one sample per clk, no stalls on the input side.

## Configuration
- PULSE_ANALYZER_AREA_EN defined: area accumulator built, pulse_area reports the saturating sum.
- Not defined: no accumulator, pulse_area tied to 0; all other behaviour identical.

## Structure
- package_settings gains SIZE_TIMESTAMP (32), SIZE_WIDTH (8), SIZE_AREA (SIZE_FILTER_DATA+SIZE_WIDTH), and typedef struct pulse_record_t {amplitude, time, width, area, pile_up}.
- FSM enum pulse_state_t (IDLE, ACTIVE, HOLD) lives in the package.
- One sub-module: pulse_record_buffer (single-entry valid/ready register with drop counter).

## Test plan
- threshold=100, samples 0,50,150,300,200,120,80,0, pulse_ready=1 -> one record: amplitude 300, width 4, area 770, pile_up 0, time = timestamp of 300, pulse_valid 1 cycle after 80 captured.
- Equal peaks 100,250,250,90 (threshold 100) -> amplitude 250, time of first 250.
- 70 samples of 500, threshold 100, MAX_WIDTH=64 -> width 70, pile_up 1.
- pulse_ready=0, two pulses separated by > HOLDOFF -> first record held unchanged, lost_count=1; then ready=1 -> pulse_valid drops next cycle.
- Trigger, change threshold 100->1000 mid-pulse, samples stay at 400 -> pulse continues, ends on sample <100.
- Assert reset low mid-ACTIVE with pulse_valid=1 -> all outputs 0 immediately; next pulse after release measured correctly.
